// File: rtl/ripple_carry_adder_16bit.sv
// Registered 16-bit ripple-carry adder (explicit full-adder chain, one cycle latency).
// Define RCA16_OVERFLOW_EN to add a registered signed-overflow output.
module ripple_carry_adder_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out,
`ifdef RCA16_OVERFLOW_EN
    output logic        overflow,
`endif
    output logic        out_valid
);

    logic [16:0] c;
    logic [15:0] s;

    // Carry ripples bit 0 -> bit 15 through one full-adder cell per bit.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = c_in;
        for (int i = 0; i < 16; i++) begin
            s[i]   = in1[i] ^ in2[i] ^ c[i];
            c[i+1] = (in1[i] & in2[i]) | (in1[i] & c[i]) | (in2[i] & c[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum       <= 16'h0000;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            sum       <= s;
            c_out     <= c[16];
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef RCA16_OVERFLOW_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (in_valid) begin
            overflow <= c[15] ^ c[16];
        end
    end
`endif

endmodule

// File: tb/tb_ripple_carry_adder_16bit.sv
// Scoreboard bench for ripple_carry_adder_16bit; covers the RCA16_OVERFLOW_EN build too.
module tb_ripple_carry_adder_16bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        c_in;
    logic [15:0] sum;
    logic        c_out;
    logic        out_valid;
    logic        ovf_act;

`ifdef RCA16_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
    logic overflow;
    assign ovf_act = overflow;
`else
    localparam bit OVF_EN = 1'b0;
    assign ovf_act = 1'b0;
`endif

    ripple_carry_adder_16bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .c_in      (c_in),
        .sum       (sum),
        .c_out     (c_out),
`ifdef RCA16_OVERFLOW_EN
        .overflow  (overflow),
`endif
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        ov;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
    } op_t;

    // Drive one cycle of stimulus; a valid, non-reset operand pushes its reference result.
    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic ci);
        logic [16:0] r;
        exp_t        e;
        in_valid = v;
        in1      = a;
        in2      = b;
        c_in     = ci;
        if (v === 1'b1 && rst_n === 1'b1) begin
            r     = {1'b0, a} + {1'b0, b} + {16'd0, ci};
            e.sum = r[15:0];
            e.co  = r[16];
            e.ov  = (a[15] == b[15]) && (r[15] != a[15]);
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 16'hxxxx, 16'hxxxx, 1'bx);
        step();
        step();
        n_cmp++;
        if ({sum, c_out, out_valid, ovf_act} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset: got sum=%h c_out=%b out_valid=%b ovf=%b, want all zero",
                     sum, c_out, out_valid, ovf_act);
        end
        last  = '{16'h0000, 1'b0, 1'b0};
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        op_t  ops[5];
        exp_t e;
        ops[0] = '{16'd3245,  16'd16785, 1'b0};
        ops[1] = '{16'd3245,  16'd16785, 1'b1};
        ops[2] = '{16'd25000, 16'd40535, 1'b0};
        ops[3] = '{16'd25001, 16'd40535, 1'b0};
        ops[4] = '{16'd25001, 16'd40535, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ops[i].a, ops[i].b, ops[i].ci);
            step();
            e = sb.pop_front();
            last = e;
            n_cmp++;
            if ({sum, c_out, out_valid, ovf_act} !== {e.sum, e.co, 1'b1, OVF_EN & e.ov}) begin
                n_err++;
                $display("FAIL basic[%0d]: got sum=%0d c_out=%b out_valid=%b ovf=%b, want sum=%0d c_out=%b out_valid=1 ovf=%b",
                         i, sum, c_out, out_valid, ovf_act, e.sum, e.co, OVF_EN & e.ov);
            end
        end
    endtask

    task automatic test_boundaries();
        op_t  ops[5];
        exp_t e;
        ops[0] = '{16'hFFFF, 16'h0000, 1'b1};
        ops[1] = '{16'hFFFF, 16'hFFFF, 1'b1};
        ops[2] = '{16'h0000, 16'h0000, 1'b0};
        ops[3] = '{16'h7FFF, 16'h0001, 1'b0};
        ops[4] = '{16'h8000, 16'h8000, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ops[i].a, ops[i].b, ops[i].ci);
            step();
            e = sb.pop_front();
            last = e;
            n_cmp++;
            if ({sum, c_out, out_valid, ovf_act} !== {e.sum, e.co, 1'b1, OVF_EN & e.ov}) begin
                n_err++;
                $display("FAIL boundary[%0d]: got sum=%h c_out=%b out_valid=%b ovf=%b, want sum=%h c_out=%b out_valid=1 ovf=%b",
                         i, sum, c_out, out_valid, ovf_act, e.sum, e.co, OVF_EN & e.ov);
            end
        end
    endtask

    task automatic test_overflow();
        exp_t e;
        drive(1'b1, 16'h7FFF, 16'h0001, 1'b0);
        step();
        e = sb.pop_front();
        last = e;
        n_cmp++;
        if ({sum, c_out, ovf_act} !== {16'h8000, 1'b0, OVF_EN}) begin
            n_err++;
            $display("FAIL ovf_pos: got sum=%h c_out=%b ovf=%b, want sum=8000 c_out=0 ovf=%b",
                     sum, c_out, ovf_act, OVF_EN);
        end
        drive(1'b1, 16'h8000, 16'h8000, 1'b0);
        step();
        e = sb.pop_front();
        last = e;
        n_cmp++;
        if ({sum, c_out, ovf_act} !== {16'h0000, 1'b1, OVF_EN}) begin
            n_err++;
            $display("FAIL ovf_neg: got sum=%h c_out=%b ovf=%b, want sum=0000 c_out=1 ovf=%b",
                     sum, c_out, ovf_act, OVF_EN);
        end
        // Held while idle, even with X operands.
        drive(1'b0, 16'hxxxx, 16'hxxxx, 1'bx);
        step();
        n_cmp++;
        if (ovf_act !== OVF_EN) begin
            n_err++;
            $display("FAIL ovf_hold: got ovf=%b, want %b", ovf_act, OVF_EN);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
        for (int i = 1; i <= 24; i++) begin
            step();
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL b2b[%0d]: scoreboard empty, got sum=%h", i, sum);
            end else begin
                e = sb.pop_front();
                last = e;
                n_cmp++;
                if ({sum, c_out, out_valid, ovf_act} !== {e.sum, e.co, 1'b1, OVF_EN & e.ov}) begin
                    n_err++;
                    $display("FAIL b2b[%0d]: got sum=%h c_out=%b out_valid=%b ovf=%b, want sum=%h c_out=%b out_valid=1 ovf=%b",
                             i, sum, c_out, out_valid, ovf_act, e.sum, e.co, OVF_EN & e.ov);
                end
            end
            if (i < 24)
                drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            else
                drive(1'b0, 16'hxxxx, 16'hxxxx, 1'bx);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++;
            if ({sum, c_out, out_valid, ovf_act} !== {last.sum, last.co, 1'b0, OVF_EN & last.ov}) begin
                n_err++;
                $display("FAIL idle_hold[%0d]: got sum=%h c_out=%b out_valid=%b ovf=%b, want sum=%h c_out=%b out_valid=0 ovf=%b",
                         k, sum, c_out, out_valid, ovf_act, last.sum, last.co, OVF_EN & last.ov);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 16'hFFFF, 16'h0003, 1'b1);
        step();
        last = sb.pop_front();
        rst_n = 1'b0;
        drive(1'b1, 16'h1234, 16'h0001, 1'b0);
        step();
        n_cmp++;
        if ({sum, c_out, out_valid, ovf_act} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid: got sum=%h c_out=%b out_valid=%b ovf=%b, want all zero",
                     sum, c_out, out_valid, ovf_act);
        end
        rst_n = 1'b1;
        drive(1'b0, 16'h1234, 16'h0001, 1'b0);
        step();
        n_cmp++;
        if ({sum, c_out, out_valid} !== {16'h0000, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_after: got sum=%h c_out=%b out_valid=%b, want all zero",
                     sum, c_out, out_valid);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in1      = '0;
        in2      = '0;
        c_in     = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_boundaries();
        test_overflow();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
